i2c_slave_regfile: RTL

- Parametrised I2C target (slave) with an internal byte register file, addressed by a pointer byte and auto-incremented.
- Oversamples SCL/SDA on the system clock and drives SDA open-drain only, via an output enable.
- Exposes a host-side read port and a write-event strobe so surrounding logic can observe bus writes.
- Sits as the DUT under the i2c-slave bench, replacing the bare interface hookup with real protocol behaviour.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_sync_edge.sv | 31 +++
 rtl/i2c_slave_regfile.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register file.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } i2c_state_e;

  localparam logic I2C_RW_READ = 1'b1;
  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;
  localparam int   BYTE_W      = 8;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for an asynchronous bus line plus rise/fall detect.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Flops reset high so an idle (pulled-up) bus produces no edge on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with a pointer-addressed, auto-incrementing byte register file.
// Handshake: wr_strobe is a single-clk pulse; wr_addr/wr_data are valid only while it is high (no ready).
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h42,
  parameter int         NUM_REGS    = 16,
  parameter int         PTR_W       = $clog2(NUM_REGS),
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_VAL   = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic [PTR_W-1:0] host_rd_addr,
  output logic [7:0]       host_rd_data,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy,
  output i2c_state_e       dbg_state
);

  localparam logic [8:0]       NUM_REGS_EXT = 9'(NUM_REGS);
  localparam logic [PTR_W-1:0] PTR_LAST     = PTR_W'(NUM_REGS - 1);

  logic scl_q, scl_rise, scl_fall;
  logic sda_q, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_state_e        state, state_nxt;
  logic [3:0]        bit_cnt, bit_cnt_nxt;
  logic [6:0]        rx_sh, rx_sh_nxt;
  logic [6:0]        tx_sh, tx_sh_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt, ptr_inc;
  logic              rw, rw_nxt;
  logic              busy_nxt, sda_oe_nxt, wr_strobe_nxt;
  logic [PTR_W-1:0]  wr_addr_nxt;
  logic [7:0]        wr_data_nxt;
  logic [BYTE_W-1:0] rx_byte, cur_rd;
  logic [7:0]        regs [NUM_REGS];

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (scl_i),
    .q    (scl_q),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sda_i),
    .q    (sda_q),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  assign start_det = scl_q & sda_fall;
  assign stop_det  = scl_q & sda_rise;

  // Byte completed on the current SCL rise (seven earlier bits plus this one).
  assign rx_byte = {rx_sh, sda_q};
  assign cur_rd  = regs[ptr];
  assign ptr_inc = (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);

  assign host_rd_data = regs[host_rd_addr];
  assign dbg_state    = state;

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    rx_sh_nxt     = rx_sh;
    tx_sh_nxt     = tx_sh;
    ptr_nxt       = ptr;
    rw_nxt        = rw;
    busy_nxt      = busy;
    sda_oe_nxt    = sda_oe;
    wr_strobe_nxt = 1'b0;
    wr_addr_nxt   = wr_addr;
    wr_data_nxt   = wr_data;

    if (start_det) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = 4'd0;
      sda_oe_nxt  = 1'b0;
    end else if (stop_det) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = 4'd0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: ;

        ADDR: begin
          if (scl_rise) begin
            rx_sh_nxt   = rx_byte[6:0];
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_nxt = 4'd0;
              if (rx_byte[7:1] == DEV_ADDR) begin
                state_nxt = ADDR_ACK;
                rw_nxt    = rx_byte[0];
                busy_nxt  = 1'b1;
              end else begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
              end
            end
          end
        end

        // bit_cnt 0: waiting for the fall that opens the ACK slot; 1: ACK driven.
        ADDR_ACK, PTR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              sda_oe_nxt  = 1'b1;
              bit_cnt_nxt = 4'd1;
            end else begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = 4'd0;
              if (state == ADDR_ACK && rw == I2C_RW_READ) begin
                state_nxt  = RD_DATA;
                tx_sh_nxt  = cur_rd[6:0];
                sda_oe_nxt = ~cur_rd[7];
              end else if (state == ADDR_ACK) begin
                state_nxt = PTR;
              end else begin
                state_nxt = WR_DATA;
              end
            end
          end
        end

        PTR: begin
          if (scl_rise) begin
            rx_sh_nxt   = rx_byte[6:0];
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_nxt = 4'd0;
              if ({1'b0, rx_byte} < NUM_REGS_EXT) begin
                ptr_nxt   = rx_byte[PTR_W-1:0];
                state_nxt = PTR_ACK;
              end else begin
                state_nxt = IDLE;
              end
            end
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            rx_sh_nxt   = rx_byte[6:0];
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_nxt   = 4'd0;
              wr_strobe_nxt = 1'b1;
              wr_addr_nxt   = ptr;
              wr_data_nxt   = rx_byte;
              ptr_nxt       = ptr_inc;
              state_nxt     = WR_ACK;
            end
          end
        end

        // MSB is already on the bus at entry; each fall presents the next bit.
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = 4'd0;
              state_nxt   = RD_ACK;
            end else begin
              sda_oe_nxt = ~tx_sh[6];
              tx_sh_nxt  = {tx_sh[5:0], 1'b0};
            end
          end
        end

        RD_ACK: begin
          if (scl_rise && bit_cnt == 4'd0) begin
            if (sda_q == I2C_ACK) begin
              ptr_nxt     = ptr_inc;
              bit_cnt_nxt = 4'd1;
            end else begin
              state_nxt = IDLE;
            end
          end else if (scl_fall && bit_cnt == 4'd1) begin
            state_nxt   = RD_DATA;
            bit_cnt_nxt = 4'd0;
            tx_sh_nxt   = cur_rd[6:0];
            sda_oe_nxt  = ~cur_rd[7];
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      busy      <= 1'b0;
      sda_oe    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      rx_sh     <= rx_sh_nxt;
      tx_sh     <= tx_sh_nxt;
      ptr       <= ptr_nxt;
      rw        <= rw_nxt;
      busy      <= busy_nxt;
      sda_oe    <= sda_oe_nxt;
      wr_strobe <= wr_strobe_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_data   <= wr_data_nxt;
    end
  end

  // Register array updates on the same clk that raises wr_strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else if (wr_strobe_nxt) begin
      regs[ptr] <= rx_byte;
    end
  end

endmodule
